// File: rtl/sopc_keys_if.sv
// sopc_keys_if: Avalon-MM slave bus bundle for the key/switch input PIO.
// Ports: address[1:0], chipselect, write_n, writedata[31:0] (master -> slave);
//        readdata[31:0], irq (slave -> master).
interface sopc_keys_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/sopc_keys.sv
// sopc_keys: Avalon-MM input PIO for push-buttons/switches. 2-flop synchronizer,
//   optional per-bit debounce (macro SOPC_KEYS_DEBOUNCE_EN), sticky edge capture, maskable level irq.
// Ports: clk, reset (async, active-high), bus (sopc_keys_if.slave), in_port[WIDTH-1:0] (async inputs).
//   Register map: 0 = filtered input (RO), 1 = reads 0, 2 = irq mask (RW), 3 = edge capture (W1C).
//   Zero wait states, readdata is combinational from registers.
module sopc_keys #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      EDGE_TYPE       = 1,      // 0 rise, 1 fall, 2 any
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = WIDTH'(4'hF),
  parameter int unsigned      DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  sopc_keys_if.slave       bus,
  input  logic [WIDTH-1:0] in_port
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic             wr;

  assign wr = bus.chipselect & ~bus.write_n;

  // Synchronizer resets to the idle level so released keys do not look like edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef SOPC_KEYS_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0]    db_cnt [WIDTH];
  logic [WIDTH-1:0] filt_q;

  // A bit change is accepted only after it has been stable for DEBOUNCE_CYCLES
  // cycles; any return to the current filtered value restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= IDLE_LEVEL;
      for (int i = 0; i < int'(WIDTH); i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2[i] == filt_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          filt_q[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign filtered = filt_q;
`else
  assign filtered = sync2;
`endif

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = filtered & ~prev;
      1:       edge_det = ~filtered & prev;
      default: edge_det = (filtered & ~prev) | (~filtered & prev);
    endcase
  end

  assign clr = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev         <= IDLE_LEVEL;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      prev <= filtered;
      if (wr && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
      // Set is ORed in after the clear so a coincident edge wins.
      edge_capture <= (edge_capture & ~clr) | edge_det;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata = 32'(filtered);
      2'd2:    bus.readdata = 32'(irq_mask);
      2'd3:    bus.readdata = 32'(edge_capture);
      default: bus.readdata = '0;
    endcase
  end

  assign bus.irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_sopc_keys.sv
// tb_sopc_keys: directed self-checking bench for sopc_keys.
// Ports: none. Instance a uses falling-edge capture, instance b any-edge capture.
module tb_sopc_keys;

`ifdef SOPC_KEYS_DEBOUNCE_EN
  localparam int unsigned DB  = 8;
  localparam int          LAT = 2 + 8;
`else
  localparam int unsigned DB  = 50000;
  localparam int          LAT = 2;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] in_a;
  logic [3:0] in_b;
  int         nchk;
  int         nerr;
  logic [31:0] rd;

  sopc_keys_if bus_a ();
  sopc_keys_if bus_b ();

  sopc_keys #(.WIDTH(4), .EDGE_TYPE(1), .IDLE_LEVEL(4'hF), .DEBOUNCE_CYCLES(DB)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .in_port(in_a)
  );

  sopc_keys #(.WIDTH(4), .EDGE_TYPE(2), .IDLE_LEVEL(4'hF), .DEBOUNCE_CYCLES(DB)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave), .in_port(in_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_rd(input bit sel, input logic [1:0] a, output logic [31:0] d);
    if (!sel) begin
      bus_a.address = a; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b1;
      #1 d = bus_a.readdata;
      bus_a.chipselect = 1'b0;
    end else begin
      bus_b.address = a; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b1;
      #1 d = bus_b.readdata;
      bus_b.chipselect = 1'b0;
    end
  endtask

  task automatic bus_wr(input bit sel, input logic [1:0] a, input logic [31:0] d);
    if (!sel) begin
      bus_a.address = a; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
      tick(1);
      bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
    end else begin
      bus_b.address = a; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
      tick(1);
      bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
    end
  endtask

  task automatic rd_check(input bit sel, input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    bus_rd(sel, a, d);
    check(tag, d, exp);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    reset = 1'b1;
    in_a = 4'hF;
    in_b = 4'hF;
    bus_a.address = '0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Reset state
    rd_check(0, 2'd0, 32'hF, "rst_data");
    rd_check(0, 2'd1, 32'h0, "rst_addr1");
    rd_check(0, 2'd2, 32'h0, "rst_mask");
    rd_check(0, 2'd3, 32'h0, "rst_cap");
    check("rst_irq", {31'd0, bus_a.irq}, 32'd0);

    // Falling edge on bit 0, masked in
    bus_wr(0, 2'd2, 32'h5);
    rd_check(0, 2'd2, 32'h5, "mask_rd");
    in_a = 4'hE;
    tick(LAT);
    rd_check(0, 2'd0, 32'hE, "data_after_lat");
    rd_check(0, 2'd3, 32'h0, "cap_not_yet");
    tick(1);
    rd_check(0, 2'd3, 32'h1, "cap_fall_b0");
    check("irq_b0", {31'd0, bus_a.irq}, 32'd1);
    bus_wr(0, 2'd3, 32'h1);
    rd_check(0, 2'd3, 32'h0, "cap_cleared");
    check("irq_cleared", {31'd0, bus_a.irq}, 32'd0);

    // Masked bit 1 captures but does not interrupt
    in_a = 4'hC;
    tick(LAT + 1);
    rd_check(0, 2'd3, 32'h2, "cap_b1");
    check("irq_b1_masked", {31'd0, bus_a.irq}, 32'd0);

    // Rising edge ignored in falling mode; then re-arm bit 0
    in_a = 4'hD;
    tick(LAT + 1);
    rd_check(0, 2'd3, 32'h2, "rise_ignored");
    in_a = 4'hC;
    tick(LAT + 1);
    rd_check(0, 2'd3, 32'h3, "cap_b0_b1");
    bus_wr(0, 2'd3, 32'h2);
    rd_check(0, 2'd3, 32'h1, "clear_b1_only");

    // Clear coinciding with a new falling edge on bit 0: set wins
    in_a = 4'hD;
    tick(LAT + 1);
    in_a = 4'hC;
    tick(LAT);
    bus_wr(0, 2'd3, 32'h1);
    rd_check(0, 2'd3, 32'h1, "set_wins");
    check("irq_set_wins", {31'd0, bus_a.irq}, 32'd1);

    // Any-edge instance: bit 3 low then high
    in_b = 4'h7;
    tick(LAT + 1);
    rd_check(1, 2'd3, 32'h8, "any_fall_b3");
    bus_wr(1, 2'd3, 32'h8);
    rd_check(1, 2'd3, 32'h0, "any_cleared");
    in_b = 4'hF;
    tick(LAT + 1);
    rd_check(1, 2'd3, 32'h8, "any_rise_b3");

    // Reset mid-operation with capture 0x3 and mask 0xF
    bus_wr(0, 2'd2, 32'hF);
    in_a = 4'hE;
    tick(LAT + 1);
    in_a = 4'hC;
    tick(LAT + 1);
    rd_check(0, 2'd3, 32'h3, "pre_rst_cap");
    check("pre_rst_irq", {31'd0, bus_a.irq}, 32'd1);
    #3 reset = 1'b1;
    #1;
    check("async_rst_irq", {31'd0, bus_a.irq}, 32'd0);
    rd_check(0, 2'd3, 32'h0, "async_rst_cap");
    rd_check(0, 2'd2, 32'h0, "async_rst_mask");
    rd_check(0, 2'd0, 32'hF, "async_rst_data");
    in_a = 4'hF;
    tick(2);
    reset = 1'b0;
    tick(LAT + 2);
    rd_check(0, 2'd0, 32'hF, "post_rst_data");
    rd_check(0, 2'd3, 32'h0, "post_rst_cap");
    rd_check(0, 2'd2, 32'h0, "post_rst_mask");

`ifdef SOPC_KEYS_DEBOUNCE_EN
    // Short glitch on bit 2 is filtered out
    in_a = 4'hB;
    tick(5);
    in_a = 4'hF;
    tick(15);
    rd_check(0, 2'd0, 32'hF, "db_glitch_data");
    rd_check(0, 2'd3, 32'h0, "db_glitch_cap");
    // Sustained low is accepted after 2 + DEBOUNCE_CYCLES cycles
    in_a = 4'hB;
    tick(9);
    rd_check(0, 2'd0, 32'hF, "db_not_yet");
    tick(1);
    rd_check(0, 2'd0, 32'hB, "db_accepted");
    tick(1);
    rd_check(0, 2'd3, 32'h4, "db_cap_b2");
    tick(9);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
